// File: rtl/hv_ppl_ctl_if.sv
// Issue/retire bundle between instr_dec, hv_ppl_ctl and gp_regs/wb_sel.
// The master drives decoder-side inputs; the slave (hv_ppl_ctl) returns stall and the stage views.
interface hv_ppl_ctl_if #(
  parameter int unsigned OP_W   = 6,
  parameter int unsigned RIDX_W = 4,
  parameter int unsigned CNT_W  = 16
);
  logic              issue_vld_i;
  logic [OP_W-1:0]   opcode_i;
  logic              wen_d_i;
  logic [RIDX_W-1:0] reg_d_idx_i;
  logic [1:0]        wrd_scope_i;
  logic              ren_a_i;
  logic              ren_b_i;
  logic [RIDX_W-1:0] reg_a_idx_i;
  logic [RIDX_W-1:0] reg_b_idx_i;
  logic              mem_wait_i;
  logic              flush_i;
  logic              stall_o;
  logic [OP_W-1:0]   ex_opcode_o;
  logic [OP_W-1:0]   wb_opcode_o;
  logic              wb_wen_o;
  logic [RIDX_W-1:0] wb_reg_idx_o;
  logic [1:0]        wb_scope_o;
  logic [CNT_W-1:0]  bubble_cnt_o;

  modport master (
    output issue_vld_i, opcode_i, wen_d_i, reg_d_idx_i, wrd_scope_i,
           ren_a_i, ren_b_i, reg_a_idx_i, reg_b_idx_i, mem_wait_i, flush_i,
    input  stall_o, ex_opcode_o, wb_opcode_o, wb_wen_o, wb_reg_idx_o,
           wb_scope_o, bubble_cnt_o
  );

  modport slave (
    input  issue_vld_i, opcode_i, wen_d_i, reg_d_idx_i, wrd_scope_i,
           ren_a_i, ren_b_i, reg_a_idx_i, reg_b_idx_i, mem_wait_i, flush_i,
    output stall_o, ex_opcode_o, wb_opcode_o, wb_wen_o, wb_reg_idx_o,
           wb_scope_o, bubble_cnt_o
  );
endinterface

// File: rtl/hv_ppl_ctl.sv
// Sideband pipe (opcode/wen/reg_d/scope) from issue to write-back with RAW bubble
// insertion, freeze on data-memory wait and young-stage kill on PC redirect.
module hv_ppl_ctl #(
  parameter int unsigned     STAGES      = 3,
  parameter int unsigned     OP_W        = 6,
  parameter int unsigned     RIDX_W      = 4,
  parameter logic [OP_W-1:0] NOP_CODE    = '0,
  parameter bit              WB_BYPASS   = 1'b0,
  parameter int unsigned     FLUSH_DEPTH = 1,
  parameter int unsigned     CNT_W       = 16
) (
  input logic         clk,
  input logic         rst_n,
  hv_ppl_ctl_if.slave bus
);

  localparam int unsigned CHK_LAST = WB_BYPASS ? (STAGES - 1) : STAGES;

  typedef struct packed {
    logic              vld;
    logic              wen;
    logic [OP_W-1:0]   op;
    logic [RIDX_W-1:0] idx;
    logic [1:0]        scope;
  } stage_t;

  localparam stage_t BUBBLE = '{vld: 1'b0, wen: 1'b0, op: NOP_CODE,
                                idx: RIDX_W'(0), scope: 2'b00};

  stage_t            stage_q [1:STAGES];
  stage_t            stage_d [1:STAGES];
  stage_t            issue_s;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              hazard_c;

  function automatic logic writes_reg(input stage_t s, input logic [RIDX_W-1:0] r);
    return s.vld & s.wen & (|s.scope) & (s.idx == r);
  endfunction

  // Incoming instruction as it would enter stage 1.
  always_comb begin
    issue_s = BUBBLE;
    if (bus.issue_vld_i) begin
      issue_s.vld   = 1'b1;
      issue_s.wen   = bus.wen_d_i;
      issue_s.op    = bus.opcode_i;
      issue_s.idx   = bus.reg_d_idx_i;
      issue_s.scope = bus.wrd_scope_i;
    end
  end

  // RAW check of both sources against every in-flight writer.
  always_comb begin
    hazard_c = 1'b0;
    for (int unsigned k = 1; k <= CHK_LAST; k++) begin
      hazard_c = hazard_c
               | (bus.ren_a_i & writes_reg(stage_q[k], bus.reg_a_idx_i))
               | (bus.ren_b_i & writes_reg(stage_q[k], bus.reg_b_idx_i));
    end
    hazard_c = hazard_c & bus.issue_vld_i;
  end

  assign bus.stall_o = bus.mem_wait_i | (hazard_c & ~bus.flush_i);

  // Next-state: flush > mem_wait > hazard > normal advance.
  always_comb begin
    stage_d = stage_q;
    cnt_d   = cnt_q;
    if (bus.flush_i) begin
      for (int unsigned k = 1; k <= FLUSH_DEPTH; k++) begin
        stage_d[k] = BUBBLE;
      end
      if (!bus.mem_wait_i) begin
        // Killed contents must not slide into stage FLUSH_DEPTH+1.
        for (int unsigned k = 2; k <= STAGES; k++) begin
          stage_d[k] = (k <= FLUSH_DEPTH + 1) ? BUBBLE : stage_q[k-1];
        end
      end
    end else if (!bus.mem_wait_i) begin
      stage_d[1] = hazard_c ? BUBBLE : issue_s;
      for (int unsigned k = 2; k <= STAGES; k++) begin
        stage_d[k] = stage_q[k-1];
      end
      if (hazard_c && !(&cnt_q)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 1; k <= STAGES; k++) begin
        stage_q[k] <= BUBBLE;
      end
      cnt_q <= '0;
    end else begin
      for (int unsigned k = 1; k <= STAGES; k++) begin
        stage_q[k] <= stage_d[k];
      end
      cnt_q <= cnt_d;
    end
  end

  assign bus.ex_opcode_o  = stage_q[1].op;
  assign bus.wb_opcode_o  = stage_q[STAGES].op;
  assign bus.wb_wen_o     = stage_q[STAGES].vld & stage_q[STAGES].wen;
  assign bus.wb_reg_idx_o = stage_q[STAGES].idx;
  assign bus.wb_scope_o   = stage_q[STAGES].scope;
  assign bus.bubble_cnt_o = cnt_q;

endmodule

// File: tb/tb_hv_ppl_ctl.sv
// Directed bench for hv_ppl_ctl: STAGES=3, no WB bypass, FLUSH_DEPTH=1, 4-bit bubble counter.
module tb_hv_ppl_ctl;
  localparam logic [5:0] NOP = 6'h2A;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  hv_ppl_ctl_if #(.OP_W(6), .RIDX_W(4), .CNT_W(4)) bus ();

  hv_ppl_ctl #(
    .STAGES(3), .OP_W(6), .RIDX_W(4), .NOP_CODE(NOP),
    .WB_BYPASS(1'b0), .FLUSH_DEPTH(1), .CNT_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.issue_vld_i = 1'b0; bus.opcode_i = 6'h00; bus.wen_d_i = 1'b0;
    bus.reg_d_idx_i = 4'h0; bus.wrd_scope_i = 2'b00;
    bus.ren_a_i = 1'b0; bus.ren_b_i = 1'b0; bus.reg_a_idx_i = 4'h0; bus.reg_b_idx_i = 4'h0;
    bus.mem_wait_i = 1'b0; bus.flush_i = 1'b0;
  endtask

  task automatic issue(input logic [5:0] op, input logic wen, input logic [3:0] rd,
                       input logic [1:0] sc, input logic ra_en, input logic [3:0] ra,
                       input logic rb_en, input logic [3:0] rb);
    bus.issue_vld_i = 1'b1; bus.opcode_i = op; bus.wen_d_i = wen;
    bus.reg_d_idx_i = rd; bus.wrd_scope_i = sc;
    bus.ren_a_i = ra_en; bus.reg_a_idx_i = ra; bus.ren_b_i = rb_en; bus.reg_b_idx_i = rb;
  endtask

  initial begin
    // 1: reset with random inputs
    bus.issue_vld_i = 1'($urandom); bus.opcode_i = 6'($urandom); bus.wen_d_i = 1'($urandom);
    bus.reg_d_idx_i = 4'($urandom); bus.wrd_scope_i = 2'($urandom);
    bus.ren_a_i = 1'($urandom); bus.ren_b_i = 1'($urandom);
    bus.reg_a_idx_i = 4'($urandom); bus.reg_b_idx_i = 4'($urandom);
    bus.mem_wait_i = 1'b1; bus.flush_i = 1'($urandom);
    tick(); tick();
    chk("rst_wb_wen", 16'(bus.wb_wen_o), 16'h0);
    chk("rst_wb_op", 16'(bus.wb_opcode_o), 16'(NOP));
    chk("rst_ex_op", 16'(bus.ex_opcode_o), 16'(NOP));
    chk("rst_cnt", 16'(bus.bubble_cnt_o), 16'h0);
    chk("rst_stall_mw1", 16'(bus.stall_o), 16'h1);
    bus.mem_wait_i = 1'b0; #1;
    chk("rst_stall_mw0", 16'(bus.stall_o), 16'h0);
    idle();
    rst_n = 1'b1;
    tick();

    // 2: ADD r3 then SUB reading r3 -> three bubbles
    issue(6'h01, 1'b1, 4'd3, 2'b11, 1'b0, 4'd0, 1'b0, 4'd0); #1;
    chk("add_nostall", 16'(bus.stall_o), 16'h0);
    tick();
    chk("add_ex", 16'(bus.ex_opcode_o), 16'h01);
    issue(6'h02, 1'b1, 4'd4, 2'b11, 1'b1, 4'd3, 1'b0, 4'd0); #1;
    chk("haz_s1", 16'(bus.stall_o), 16'h1);
    tick();
    chk("haz_ex_bubble", 16'(bus.ex_opcode_o), 16'(NOP));
    chk("haz_s2", 16'(bus.stall_o), 16'h1);
    tick();
    chk("add_wb_op", 16'(bus.wb_opcode_o), 16'h01);
    chk("add_wb_wen", 16'(bus.wb_wen_o), 16'h1);
    chk("add_wb_idx", 16'(bus.wb_reg_idx_o), 16'h3);
    chk("haz_s3", 16'(bus.stall_o), 16'h1);
    tick();
    chk("haz_cnt3", 16'(bus.bubble_cnt_o), 16'h3);
    chk("haz_clear", 16'(bus.stall_o), 16'h0);
    tick();
    chk("sub_ex", 16'(bus.ex_opcode_o), 16'h02);
    idle();
    tick(); tick();
    chk("sub_wb_op", 16'(bus.wb_opcode_o), 16'h02);
    chk("sub_wb_idx", 16'(bus.wb_reg_idx_o), 16'h4);

    // 3: scope 0 write does not create a hazard
    issue(6'h03, 1'b1, 4'd5, 2'b00, 1'b0, 4'd0, 1'b0, 4'd0);
    tick();
    issue(6'h04, 1'b0, 4'd0, 2'b00, 1'b1, 4'd5, 1'b1, 4'd5); #1;
    chk("scope0_nostall", 16'(bus.stall_o), 16'h0);
    tick();
    chk("scope0_ex", 16'(bus.ex_opcode_o), 16'h04);
    chk("scope0_cnt", 16'(bus.bubble_cnt_o), 16'h3);
    idle();
    tick(); tick(); tick();

    // 4: mem_wait freezes a full pipe for 4 cycles
    issue(6'h11, 1'b1, 4'd1, 2'b01, 1'b0, 4'd0, 1'b0, 4'd0); tick();
    issue(6'h12, 1'b1, 4'd2, 2'b10, 1'b0, 4'd0, 1'b0, 4'd0); tick();
    issue(6'h13, 1'b1, 4'd6, 2'b11, 1'b0, 4'd0, 1'b0, 4'd0); tick();
    issue(6'h14, 1'b1, 4'd8, 2'b11, 1'b0, 4'd0, 1'b0, 4'd0);
    bus.mem_wait_i = 1'b1; #1;
    chk("mw_stall", 16'(bus.stall_o), 16'h1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("mw_wb_op%0d", i), 16'(bus.wb_opcode_o), 16'h11);
      chk($sformatf("mw_wb_wen%0d", i), 16'(bus.wb_wen_o), 16'h1);
      chk($sformatf("mw_ex%0d", i), 16'(bus.ex_opcode_o), 16'h13);
    end
    idle();
    tick();
    chk("mw_rel_wb_op", 16'(bus.wb_opcode_o), 16'h12);
    chk("mw_rel_wb_scope", 16'(bus.wb_scope_o), 16'h2);
    tick();
    chk("mw_rel_wb_op2", 16'(bus.wb_opcode_o), 16'h13);
    chk("mw_rel_wb_idx2", 16'(bus.wb_reg_idx_o), 16'h6);
    tick();
    chk("mw_drained_wen", 16'(bus.wb_wen_o), 16'h0);
    chk("mw_cnt", 16'(bus.bubble_cnt_o), 16'h3);

    // 5: flush kills LD r2 in stage 1; flush also masks a coincident hazard
    issue(6'h21, 1'b1, 4'd7, 2'b11, 1'b0, 4'd0, 1'b0, 4'd0); tick();
    issue(6'h22, 1'b1, 4'd2, 2'b11, 1'b0, 4'd0, 1'b0, 4'd0); tick();
    issue(6'h23, 1'b0, 4'd0, 2'b00, 1'b1, 4'd2, 1'b0, 4'd0); #1;
    chk("fl_pre_stall", 16'(bus.stall_o), 16'h1);
    bus.flush_i = 1'b1; #1;
    chk("fl_stall_masked", 16'(bus.stall_o), 16'h0);
    tick();
    chk("fl_old_wb_op", 16'(bus.wb_opcode_o), 16'h21);
    chk("fl_old_wb_wen", 16'(bus.wb_wen_o), 16'h1);
    chk("fl_ex_bubble", 16'(bus.ex_opcode_o), 16'(NOP));
    chk("fl_cnt", 16'(bus.bubble_cnt_o), 16'h3);
    idle();
    tick();
    chk("fl_ld_slot_wen", 16'(bus.wb_wen_o), 16'h0);
    tick();
    chk("fl_ld_slot_wen2", 16'(bus.wb_wen_o), 16'h0);
    tick();

    // 6: self-dependent writer -> 3 bubbles every 4 cycles, counter saturates
    issue(6'h31, 1'b1, 4'd1, 2'b01, 1'b1, 4'd1, 1'b0, 4'd0);
    for (int i = 0; i < 8; i++) tick();
    chk("sat_cnt9", 16'(bus.bubble_cnt_o), 16'h9);
    for (int i = 0; i < 32; i++) tick();
    chk("sat_cntF", 16'(bus.bubble_cnt_o), 16'hF);

    // asynchronous reset mid-operation
    rst_n = 1'b0; #1;
    chk("arst_wb_wen", 16'(bus.wb_wen_o), 16'h0);
    chk("arst_ex_op", 16'(bus.ex_opcode_o), 16'(NOP));
    chk("arst_cnt", 16'(bus.bubble_cnt_o), 16'h0);
    chk("arst_stall", 16'(bus.stall_o), 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
